seq_pattern_detector: RTL and testbench

Parametrised serial bit-pattern detector, the successor to the fixed 4-bit two-pattern detector. It has:
- PAT_LEN-bit history window and NUM_PAT runtime-reloadable patterns with per-pattern enable.
- Overlapping and non-overlapping match modes.
- Qualified input strobe and a saturating match counter.
It sits on a serial input stream and drives a one-cycle match pulse plus match identification to downstream control logic.

---
 rtl/seq_pattern_detector.sv | 110 +++++++++++
 tb/tb_seq_pattern_detector.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector. A qualified bit stream shifts through a PAT_LEN-bit
// window that is compared against NUM_PAT runtime-loadable pattern slots.
module seq_pattern_detector #(
    parameter int PAT_LEN = 4,
    parameter int NUM_PAT = 2,
    parameter int CNT_W = 8,
    parameter logic [NUM_PAT*PAT_LEN-1:0] PAT_INIT = {4'b0101, 4'b1001},
    parameter int IDX_W = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               x,
    input  logic               x_valid,
    input  logic               overlap,
    input  logic [NUM_PAT-1:0] pat_en,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [PAT_LEN-1:0] cfg_pat,
    input  logic               clr_cnt,
    output logic               y,
    output logic [NUM_PAT-1:0] match_vec,
    output logic [IDX_W-1:0]   match_id,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PAT_LEN-1:0] hist;
    logic [FILL_W-1:0]  fill;
    logic [PAT_LEN-1:0] pats [NUM_PAT];

    logic               accept;
    logic               cfg_hit;
    logic [PAT_LEN-1:0] hist_next;
    logic [FILL_W-1:0]  fill_next;
    logic [NUM_PAT-1:0] hit;
    logic               any_hit;
    logic [IDX_W-1:0]   hit_id;

    // Matching looks at the window as it will be after the incoming bit shifts in.
    always_comb begin
        accept    = x_valid && !cfg_we;
        cfg_hit   = cfg_we && (32'(cfg_idx) < NUM_PAT);
        hist_next = {hist[PAT_LEN-2:0], x};
        fill_next = (fill == FILL_FULL) ? fill : fill + 1'b1;
        hit       = '0;
        for (int i = 0; i < NUM_PAT; i++) begin
            hit[i] = accept && pat_en[i] && (fill_next == FILL_FULL) &&
                     (hist_next == pats[i]);
        end
        any_hit = |hit;
        hit_id  = '0;
        for (int i = NUM_PAT - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_id = IDX_W'(i);
            end
        end
    end

    // A pattern write takes the cycle, so a bit offered alongside it is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist <= '0;
            fill <= '0;
            for (int i = 0; i < NUM_PAT; i++) begin
                pats[i] <= PAT_INIT[i*PAT_LEN +: PAT_LEN];
            end
        end else if (cfg_we) begin
            if (cfg_hit) begin
                fill <= '0;
                for (int i = 0; i < NUM_PAT; i++) begin
                    if (32'(cfg_idx) == i) begin
                        pats[i] <= cfg_pat;
                    end
                end
            end
        end else if (x_valid) begin
            hist <= hist_next;
            fill <= (any_hit && !overlap) ? '0 : fill_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y         <= 1'b0;
            match_vec <= '0;
            match_id  <= '0;
        end else begin
            y         <= any_hit;
            match_vec <= hit;
            if (any_hit) begin
                match_id <= hit_id;
            end
        end
    end

    // Clear wins over a coincident match; the count sticks at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_cnt <= '0;
        end else if (clr_cnt) begin
            match_cnt <= '0;
        end else if (any_hit && (match_cnt != CNT_MAX)) begin
            match_cnt <= match_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Self-checking bench for seq_pattern_detector: vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_seq_pattern_detector;

    localparam int PAT_LEN = 4;
    localparam int NUM_PAT = 2;
    localparam int IDX_W   = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       x, x_valid, overlap, cfg_we, clr_cnt;
    logic [1:0] pat_en;
    logic       cfg_idx;
    logic [3:0] cfg_pat;

    logic       y, y_b;
    logic [1:0] match_vec, match_vec_b;
    logic       match_id, match_id_b;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt_b;

    seq_pattern_detector #(.PAT_LEN(4), .NUM_PAT(2), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .overlap(overlap),
        .pat_en(pat_en), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pat(cfg_pat),
        .clr_cnt(clr_cnt), .y(y), .match_vec(match_vec), .match_id(match_id),
        .match_cnt(match_cnt)
    );

    seq_pattern_detector #(.PAT_LEN(4), .NUM_PAT(2), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .overlap(overlap),
        .pat_en(pat_en), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pat(cfg_pat),
        .clr_cnt(clr_cnt), .y(y_b), .match_vec(match_vec_b), .match_id(match_id_b),
        .match_cnt(match_cnt_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: patterns, bits received since the last restart, counters.
    logic [3:0] m_pat [2];
    bit         m_bits [$];
    int         m_cnt8, m_cnt2;
    bit         m_y;
    logic [1:0] m_vec;
    int         m_id;

    typedef struct {
        bit       x;
        bit       xv;
        bit       exp_y;
        bit [1:0] exp_vec;
        int       exp_id;
        int       exp_cnt;
    } vec_t;

    vec_t table_v [8];

    task automatic expectVal(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_pat[0] = 4'b1001;
        m_pat[1] = 4'b0101;
        m_bits.delete();
        m_cnt8 = 0;
        m_cnt2 = 0;
        m_y    = 1'b0;
        m_vec  = 2'b00;
        m_id   = 0;
    endtask

    // Apply one clock edge worth of the current inputs to the model.
    task automatic modelEdge();
        int w;
        m_y   = 1'b0;
        m_vec = 2'b00;
        if (cfg_we) begin
            if (int'(cfg_idx) < NUM_PAT) begin
                m_pat[cfg_idx] = cfg_pat;
                m_bits.delete();
            end
        end else if (x_valid) begin
            m_bits.push_back(x);
            if (m_bits.size() > PAT_LEN) void'(m_bits.pop_front());
            if (m_bits.size() == PAT_LEN) begin
                w = 0;
                foreach (m_bits[k]) w = w * 2 + int'(m_bits[k]);
                for (int i = 0; i < NUM_PAT; i++) begin
                    if (pat_en[i] && w == int'(m_pat[i])) m_vec[i] = 1'b1;
                end
            end
            if (m_vec != 2'b00) begin
                m_y  = 1'b1;
                m_id = m_vec[0] ? 0 : 1;
                if (!overlap) m_bits.delete();
            end
        end
        if (clr_cnt) begin
            m_cnt8 = 0;
            m_cnt2 = 0;
        end else if (m_y) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3) m_cnt2++;
        end
    endtask

    task automatic checkOutput(input string name);
        expectVal({name, ".y"}, int'(y), int'(m_y));
        expectVal({name, ".match_vec"}, int'(match_vec), int'(m_vec));
        expectVal({name, ".match_id"}, int'(match_id), m_id);
        expectVal({name, ".match_cnt"}, int'(match_cnt), m_cnt8);
        expectVal({name, ".match_cnt_b"}, int'(match_cnt_b), m_cnt2);
    endtask

    task automatic applyStimulus(input bit bx, input bit bv, input bit we, input bit idx,
                                 input logic [3:0] pat, input bit clr, input string name);
        x       = bx;
        x_valid = bv;
        cfg_we  = we;
        cfg_idx = idx;
        cfg_pat = pat;
        clr_cnt = clr;
        modelEdge();
        @(posedge clk);
        #1;
        checkOutput(name);
    endtask

    task automatic sendBit(input bit bx, input string name);
        applyStimulus(bx, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, name);
    endtask

    task automatic doReset();
        reset   = 1'b1;
        x_valid = 1'b0;
        cfg_we  = 1'b0;
        clr_cnt = 1'b0;
        x       = 1'b0;
        cfg_idx = 1'b0;
        cfg_pat = 4'h0;
        #1;
        modelReset();
        checkOutput("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        overlap = 1'b1;
        pat_en  = 2'b11;

        table_v[0] = '{1, 1, 0, 2'b00, 0, 0};
        table_v[1] = '{0, 1, 0, 2'b00, 0, 0};
        table_v[2] = '{0, 1, 0, 2'b00, 0, 0};
        table_v[3] = '{1, 1, 1, 2'b01, 0, 1};
        table_v[4] = '{0, 1, 0, 2'b00, 0, 1};
        table_v[5] = '{0, 1, 0, 2'b00, 0, 1};
        table_v[6] = '{1, 1, 1, 2'b01, 0, 2};
        table_v[7] = '{1, 0, 0, 2'b00, 0, 2};

        // Vector table: 1001001 with overlap, then an idle cycle.
        doReset();
        foreach (table_v[i]) begin
            applyStimulus(table_v[i].x, table_v[i].xv, 1'b0, 1'b0, 4'h0, 1'b0, "table");
            expectVal("tab.y", int'(y), int'(table_v[i].exp_y));
            expectVal("tab.vec", int'(match_vec), int'(table_v[i].exp_vec));
            expectVal("tab.id", int'(match_id), table_v[i].exp_id);
            expectVal("tab.cnt", int'(match_cnt), table_v[i].exp_cnt);
        end

        // Non-overlapping: 1001001 gives one match only.
        doReset();
        overlap = 1'b0;
        sendBit(1, "novl"); sendBit(0, "novl"); sendBit(0, "novl"); sendBit(1, "novl");
        expectVal("novl.y4", int'(y), 1);
        sendBit(0, "novl"); sendBit(0, "novl"); sendBit(1, "novl");
        expectVal("novl.y7", int'(y), 0);
        expectVal("novl.cnt", int'(match_cnt), 1);
        overlap = 1'b1;

        // Slot 1 match, reload slot 1, dual match, then enable mask.
        doReset();
        sendBit(0, "s1"); sendBit(1, "s1"); sendBit(0, "s1"); sendBit(1, "s1");
        expectVal("s1.vec", int'(match_vec), 2);
        expectVal("s1.id", int'(match_id), 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'b1001, 1'b0, "cfg");
        sendBit(1, "dual"); sendBit(0, "dual"); sendBit(0, "dual");
        expectVal("cfg.nomatch", int'(y), 0);
        sendBit(1, "dual");
        expectVal("dual.vec", int'(match_vec), 3);
        expectVal("dual.id", int'(match_id), 0);
        expectVal("dual.cnt", int'(match_cnt), 2);
        pat_en = 2'b01;
        sendBit(0, "mask"); sendBit(0, "mask"); sendBit(1, "mask");
        expectVal("mask.vec", int'(match_vec), 1);
        pat_en = 2'b11;

        // Reset mid-stream discards partial history.
        doReset();
        sendBit(1, "mid"); sendBit(0, "mid"); sendBit(0, "mid");
        doReset();
        sendBit(1, "mid");
        expectVal("mid.y1", int'(y), 0);
        sendBit(0, "mid"); sendBit(0, "mid");
        sendBit(1, "mid");
        expectVal("mid.y4", int'(y), 1);

        // Gaps in x_valid with x toggling do not disturb the window.
        doReset();
        sendBit(1, "gap");
        for (int g = 0; g < 3; g++) applyStimulus(g[0], 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, "gap");
        expectVal("gap.y", int'(y), 0);
        sendBit(0, "gap");
        for (int g = 0; g < 3; g++) applyStimulus(~g[0], 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, "gap");
        sendBit(0, "gap");
        sendBit(1, "gap");
        expectVal("gap.match", int'(y), 1);

        // Narrow counter saturates, then clear beats a coincident match.
        doReset();
        sendBit(1, "sat"); sendBit(0, "sat"); sendBit(0, "sat"); sendBit(1, "sat");
        expectVal("sat.c1", int'(match_cnt_b), 1);
        for (int m = 2; m <= 6; m++) begin
            sendBit(0, "sat"); sendBit(0, "sat"); sendBit(1, "sat");
            expectVal("sat.cn", int'(match_cnt_b), (m < 3) ? m : 3);
        end
        sendBit(0, "sat"); sendBit(0, "sat");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, "clr");
        expectVal("clr.y", int'(y), 1);
        expectVal("clr.cnt_b", int'(match_cnt_b), 0);
        expectVal("clr.cnt", int'(match_cnt), 0);

        // Randomized run against the model.
        doReset();
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 99) < 5) overlap = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 99) < 5) pat_en = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 499) == 0) begin
                doReset();
            end else begin
                applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                              $urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1,
                              4'($urandom_range(0, 15)), $urandom_range(0, 99) < 2, "rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
